// File: rtl/decode_issue.sv
// decode_issue: single-slot decode/issue stage for a small in-order ALU pipe.
// Keeps a register file plus per-register busy bits. Instructions with an
// outstanding write to any referenced register are held off via in_ready.
// Downstream writebacks update the file, release busy bits, and bypass into
// operand reads in the same cycle.
module decode_issue #(
  parameter int DATA_W = 16,
  parameter int NREG   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [31:0]       in_instr,
  output logic              in_ready,
  output logic              out_valid,
  output logic [7:0]        out_opCode,
  output logic [DATA_W-1:0] out_opA,
  output logic [DATA_W-1:0] out_opB,
  output logic [15:0]       out_imm,
  output logic [3:0]        out_rd,
  input  logic              wb_en,
  input  logic [3:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              illegal
);

  localparam int AW = 4;

  localparam logic [7:0] OP_NOP = 8'd0;
  localparam logic [7:0] OP_ADD = 8'd1;
  localparam logic [7:0] OP_OR  = 8'd4;

  // Instruction fields
  logic [7:0]    opc;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] rs1_idx;
  logic [AW-1:0] rs2_idx;
  logic [15:0]   imm;

  assign opc     = in_instr[31:24];
  assign rd_idx  = in_instr[23:20];
  assign rs1_idx = in_instr[19:16];
  assign rs2_idx = in_instr[15:12];
  assign imm     = in_instr[15:0];

  // Decode classes: ALU ops touch registers; NOP/illegal pass straight through
  logic is_alu;
  logic is_legal;

  assign is_alu   = (opc >= OP_ADD) && (opc <= OP_OR);
  assign is_legal = (opc <= OP_OR);

  // Architectural state
  logic [DATA_W-1:0] regs_q [NREG];
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;

  // Per-register writeback hit and the busy view after this cycle's writeback
  logic [NREG-1:0] wb_hit;
  logic [NREG-1:0] busy_eff;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_wb_hit
      assign wb_hit[gi]   = wb_en && (wb_addr == AW'(gi));
      assign busy_eff[gi] = busy_q[gi] & ~wb_hit[gi];
    end
  endgenerate

  // Hazard: an ALU op may not issue while any referenced register awaits a result
  logic hazard;
  logic accept;
  logic issue;

  assign hazard   = is_alu && (busy_eff[rs1_idx] || busy_eff[rs2_idx] || busy_eff[rd_idx]);
  assign in_ready = ~hazard;
  assign accept   = in_valid && in_ready;
  assign issue    = accept && is_alu;

  // Operand read: r0 is hard zero, otherwise same-cycle writeback data wins
  logic [DATA_W-1:0] opa_d;
  logic [DATA_W-1:0] opb_d;

  always_comb begin
    opa_d = '0;
    opb_d = '0;
    if (rs1_idx != '0) begin
      opa_d = wb_hit[rs1_idx] ? wb_data : regs_q[rs1_idx];
    end
    if (rs2_idx != '0) begin
      opb_d = wb_hit[rs2_idx] ? wb_data : regs_q[rs2_idx];
    end
  end

  // Next busy state: writeback clears, issue sets; set applied last so it wins.
  // r0 can never become busy.
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_busy_next
      if (gi == 0) begin : g_r0
        assign busy_d[gi] = 1'b0;
      end else begin : g_rn
        assign busy_d[gi] = busy_eff[gi] | (issue && (rd_idx == AW'(gi)));
      end
    end
  endgenerate

  // Busy bit register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Register file: one writable entry per register; r0 stays at zero
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_rf
      if (gi == 0) begin : g_r0
        // r0 is a constant-zero entry; writes to it are discarded
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            regs_q[gi] <= '0;
          end else begin
            regs_q[gi] <= '0;
          end
        end
      end else begin : g_rn
        // Writeback updates the entry whether or not it was busy
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            regs_q[gi] <= '0;
          end else if (wb_hit[gi]) begin
            regs_q[gi] <= wb_data;
          end
        end
      end
    end
  endgenerate

  // Issue slot registers: payload only moves on an ALU issue, valid every cycle
  logic              out_valid_q;
  logic [7:0]        out_opcode_q;
  logic [DATA_W-1:0] out_opa_q;
  logic [DATA_W-1:0] out_opb_q;
  logic [15:0]       out_imm_q;
  logic [AW-1:0]     out_rd_q;
  logic              illegal_q;

  // Issue slot and illegal-opcode pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_opcode_q <= OP_NOP;
      out_opa_q    <= '0;
      out_opb_q    <= '0;
      out_imm_q    <= '0;
      out_rd_q     <= '0;
      illegal_q    <= 1'b0;
    end else begin
      out_valid_q <= issue;
      illegal_q   <= accept && !is_legal;
      if (issue) begin
        out_opcode_q <= opc;
        out_opa_q    <= opa_d;
        out_opb_q    <= opb_d;
        out_imm_q    <= imm;
        out_rd_q     <= rd_idx;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_opCode = out_opcode_q;
  assign out_opA    = out_opa_q;
  assign out_opB    = out_opb_q;
  assign out_imm    = out_imm_q;
  assign out_rd     = out_rd_q;
  assign illegal    = illegal_q;

endmodule

// File: doc/decode_issue.md
DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, the operand/register width (fixed at 16 for this revision).
REQ-002 The block SHALL have parameter NREG, default 16, the number of architectural registers (index width 4).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid  input  1  instruction word present.
REQ-006 The block SHALL have port in_instr  input  32  instruction: [31:24] opcode, [23:20] rd, [19:16] rs1, [15:12] rs2, [15:0] imm.
REQ-007 The block SHALL have port in_ready  output  1  instruction accepted this cycle when in_valid and in_ready are both 1.
REQ-008 The block SHALL have port out_valid  output  1  issue slot valid for the ALU this cycle.
REQ-009 The block SHALL have port out_opCode  output  8  opcode to ALU.
REQ-010 The block SHALL have port out_opA / out_opB  output  16 each  source operands to ALU.
REQ-011 The block SHALL have port out_imm  output  16  immediate to ALU.
REQ-012 The block SHALL have port out_rd  output  4  destination tag accompanying the issue.
REQ-013 The block SHALL have port wb_en  input  1  result writeback strobe from downstream.
REQ-014 The block SHALL have port wb_addr  input  4  writeback register index.
REQ-015 The block SHALL have port wb_data  input  16  writeback value.
REQ-016 The block SHALL have port illegal  output  1  one-cycle pulse: an accepted opcode was not legal.

Function
REQ-017 Legal opcodes SHALL be 8'd0 NOP, 8'd1 ADD, 8'd2 SUB, 8'd3 AND, 8'd4 OR; all other values are illegal.
REQ-018 The block SHALL hold an NREG x DATA_W register file; r0 reads 0 always and writes to r0 are discarded.
REQ-019 The block SHALL hold one busy bit per register; r0 is never busy.
REQ-020 in_ready SHALL be combinational: 1 unless the instruction is ADD..OR and any of rs1, rs2, rd is busy after clearing by this cycle's wb_en/wb_addr.
REQ-021 On acceptance of ADD..OR: next edge registers out_valid=1, out_opCode, out_opA=R[rs1], out_opB=R[rs2], out_imm=instr[15:0], out_rd=rd, and sets busy[rd] (rd!=0).
REQ-022 On acceptance of NOP or an illegal opcode: next edge out_valid=0, no busy bit changes; illegal=1 for that one cycle when the opcode is illegal.
REQ-023 NOP and illegal opcodes SHALL never stall (in_ready=1).
REQ-024 Cycles without acceptance SHALL register out_valid=0; out_opCode/opA/opB/imm/rd hold their previous values.
REQ-025 Latency SHALL be exactly one cycle from acceptance edge to out_valid; throughput is one instruction per cycle when there is no hazard.
REQ-026 wb_en SHALL write wb_data into R[wb_addr] and clear busy[wb_addr] at the edge.
REQ-027 Operand read of a register being written in the same cycle SHALL return wb_data (write-through bypass).
REQ-028 When wb clears and issue sets the same busy bit in one cycle, set SHALL win.
REQ-029 wb_en to a register that is not busy SHALL still update R and is not an error.
REQ-030 Operand arithmetic is not performed here; values SHALL pass unmodified at 16 bits.

Reset
REQ-031 While rst_n=0, out_valid=0, illegal=0, out_opCode/opA/opB/imm/rd=0, all busy bits=0, all registers=0, independent of clk.
REQ-032 in_ready SHALL equal 1 during and immediately after reset.
REQ-033 Assertion of rst_n mid-stall SHALL discard the pending instruction; no busy bit survives.

Verification
REQ-034 After reset, write r1=5 and r2=3 via wb; issue ADD r3,r1,r2 -> next cycle out_valid=1, opCode=1, opA=5, opB=3, out_rd=3.
REQ-035 Issue SUB r4,r3,r1 one cycle after ADD to r3 with no wb -> in_ready=0 until wb_en to r3; then issue with opA=wb_data of that cycle.
REQ-036 Same-cycle wb_en r5=0x1234 and in_valid OR r6,r5,r0 -> accepted, opA=0x1234, opB=0, busy[6] set.
REQ-037 Opcode 8'hFF accepted -> illegal pulses 1 cycle, out_valid=0, in_ready stays 1; back-to-back NOPs -> out_valid stays 0.
REQ-038 ADD r0,r1,r1 then read r0 -> opA=0; busy[0] never set; wb_en to r0 with 0xFFFF -> r0 still reads 0.
REQ-039 Drop rst_n while stalled on busy r3 -> outputs 0 immediately; after release in_ready=1 and r3 reads 0.
